// File: rtl/encoder_fixed_point_serial_pkg.sv
// Shared definitions for the serial fixed-point encoder: word format,
// FSM state encodings and common Q8.8 constants.
package encoder_fixed_point_serial_pkg;

  localparam int BITSIZE_DEF = 16;
  localparam int FRAC_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] ONE  = 16'h0100;
  localparam logic [15:0] HALF = 16'h0080;

endpackage

// File: rtl/encoder_fixed_point_serial_mac.sv
// Combinational multiply-accumulate: sum = acc + trunc((a*b) >>> FRAC),
// all arithmetic wraps at BITSIZE bits to match the decoder's chain.
module encoder_fixed_point_serial_mac
  import encoder_fixed_point_serial_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF,
  parameter int FRAC    = FRAC_DEF
) (
  input  logic signed [BITSIZE-1:0] acc,
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] b,
  output logic signed [BITSIZE-1:0] sum
);

  localparam int PW = 2 * BITSIZE;

  logic signed [PW-1:0] prod;

  assign prod = PW'(a) * PW'(b);
  // Floor shift, then keep the low word exactly like fixed_point_multiply.
  assign sum  = acc + BITSIZE'(prod >>> FRAC);

endmodule

// File: rtl/encoder_fixed_point_serial.sv
// Serial encoder layer z = W*x + b using one time-multiplexed MAC unit.
// state | meaning
// IDLE  | ready for a new vector
// MAC   | one product per edge, i over inputs, j over outputs
// DONE  | result valid, waiting for out_ready
module encoder_fixed_point_serial
  import encoder_fixed_point_serial_pkg::*;
#(
  parameter int N_input  = 9,
  parameter int M_output = 2,
  parameter int BITSIZE  = BITSIZE_DEF,
  parameter int FRAC     = FRAC_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_input*BITSIZE-1:0]          x,
  input  logic [N_input*M_output*BITSIZE-1:0] w,
  input  logic [M_output*BITSIZE-1:0]         b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [M_output*BITSIZE-1:0]     out
);

  localparam int IW = (N_input  > 1) ? $clog2(N_input)  : 1;
  localparam int JW = (M_output > 1) ? $clog2(M_output) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_input - 1);
  localparam logic [JW-1:0] J_LAST = JW'(M_output - 1);

  state_t state_q, state_d;

  logic [N_input*BITSIZE-1:0]          x_reg;
  logic [N_input*M_output*BITSIZE-1:0] w_reg;
  logic [M_output*BITSIZE-1:0]         b_reg;
  logic [IW-1:0]      i_q;
  logic [JW-1:0]      j_q, j_inc;
  logic [BITSIZE-1:0] acc_q, acc_next;

  logic [BITSIZE-1:0] x_arr   [N_input];
  logic [BITSIZE-1:0] w_arr   [M_output][N_input];
  logic [BITSIZE-1:0] b_arr   [M_output];
  logic [BITSIZE-1:0] out_arr [M_output];

  for (genvar gi = 0; gi < N_input; gi++) begin : g_x
    assign x_arr[gi] = x_reg[gi*BITSIZE +: BITSIZE];
    for (genvar gj = 0; gj < M_output; gj++) begin : g_w
      assign w_arr[gj][gi] = w_reg[(gj*N_input+gi)*BITSIZE +: BITSIZE];
    end
  end

  for (genvar gj = 0; gj < M_output; gj++) begin : g_out
    assign b_arr[gj] = b_reg[gj*BITSIZE +: BITSIZE];
    assign out[gj*BITSIZE +: BITSIZE] = out_arr[gj];
  end

  assign j_inc = j_q + 1'b1;

  encoder_fixed_point_serial_mac #(
    .BITSIZE(BITSIZE),
    .FRAC   (FRAC)
  ) u_mac (
    .acc(acc_q),
    .a  (x_arr[i_q]),
    .b  (w_arr[j_q][i_q]),
    .sum(acc_next)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = MAC;
      MAC:  if (i_q == I_LAST && j_q == J_LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg <= '0;
      w_reg <= '0;
      b_reg <= '0;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
      for (int k = 0; k < M_output; k++) out_arr[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_reg <= x;
            w_reg <= w;
            b_reg <= b;
            acc_q <= b[BITSIZE-1:0];
            i_q   <= '0;
            j_q   <= '0;
          end
        end
        MAC: begin
          if (i_q != I_LAST) begin
            acc_q <= acc_next;
            i_q   <= i_q + 1'b1;
          end else begin
            out_arr[j_q] <= acc_next;
            i_q          <= '0;
            if (j_q != J_LAST) begin
              j_q   <= j_inc;
              acc_q <= b_arr[j_inc];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_fixed_point_serial.sv
// Directed self-checking bench for encoder_fixed_point_serial at default
// parameters (N_input=9, M_output=2, Q8.8).
module tb_encoder_fixed_point_serial;

  localparam int N  = 9;
  localparam int M  = 2;
  localparam int BS = 16;
  localparam int LAT = N * M;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [N*BS-1:0]   x;
  logic [N*M*BS-1:0] w;
  logic [M*BS-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [M*BS-1:0]   out;

  int errors = 0;
  int checks = 0;

  encoder_fixed_point_serial dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .w        (w),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  always #5 clk = ~clk;

  function automatic logic [N*BS-1:0] fill_x(input logic [BS-1:0] v);
    logic [N*BS-1:0] r;
    for (int i = 0; i < N; i++) r[i*BS +: BS] = v;
    return r;
  endfunction

  function automatic logic [N*M*BS-1:0] fill_w(input logic [BS-1:0] v);
    logic [N*M*BS-1:0] r;
    for (int i = 0; i < N*M; i++) r[i*BS +: BS] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Presents a vector for one accept edge, then scrambles the inputs.
  task automatic start(input logic [N*BS-1:0] xv, input logic [N*M*BS-1:0] wv,
                       input logic [M*BS-1:0] bv);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    x = xv; w = wv; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = '1; w = '1; b = '1;
  endtask

  task automatic wait_valid(input string name);
    int lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    check(name, 32'(lat), 32'(LAT));
  endtask

  task automatic run(input string name, input logic [N*BS-1:0] xv,
                     input logic [N*M*BS-1:0] wv, input logic [M*BS-1:0] bv,
                     input logic [BS-1:0] e0, input logic [BS-1:0] e1);
    start(xv, wv, bv);
    wait_valid({name, "_latency"});
    check({name, "_out0"}, 32'(out[0 +: BS]), 32'(e0));
    check({name, "_out1"}, 32'(out[BS +: BS]), 32'(e1));
    tick();
    check({name, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; w = '0; b = '0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", out, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run("basic", fill_x(16'h0100), fill_w(16'h0080), '0, 16'h0480, 16'h0480);
  endtask

  task automatic test_bias();
    run("bias", '0, fill_w(16'h0100), {16'hFF00, 16'h0100}, 16'h0100, 16'hFF00);
  endtask

  task automatic test_sign_floor();
    logic [N*BS-1:0]   xv;
    logic [N*M*BS-1:0] wv;
    xv = '0; wv = '0;
    xv[0 +: BS] = 16'hFF00; wv[0 +: BS] = 16'h0200;
    run("sign_neg", xv, wv, '0, 16'hFE00, 16'h0000);
    xv[0 +: BS] = 16'hFFFF; wv[0 +: BS] = 16'h0001;
    run("floor_neg", xv, wv, '0, 16'hFFFF, 16'h0000);
    xv[0 +: BS] = 16'h0001; wv[0 +: BS] = 16'h0001;
    run("floor_pos", xv, wv, '0, 16'h0000, 16'h0000);
  endtask

  task automatic test_wrap();
    run("wrap", fill_x(16'h7F00), fill_w(16'h0100), '0, 16'h7700, 16'h7700);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    // each product 1.0, sum 9.0 plus bias
    start(fill_x(16'h0100), fill_w(16'h0100), {16'h0001, 16'h0002});
    wait_valid("bp_latency");
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        x = '0; w = '0; b = '0; in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_out", out, {16'h0901, 16'h0902});
    end
    out_ready = 1'b1;
    tick();
    check("bp_valid_fall", 32'(out_valid), 32'd0);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    run("bp_next", fill_x(16'h0200), fill_w(16'h0080), {16'h0000, 16'h0010},
        16'h0910, 16'h0900);
  endtask

  task automatic test_reset_mid_mac();
    start(fill_x(16'h0100), fill_w(16'h0100), '0);
    repeat (7) tick();
    reset = 1'b1;
    #1;
    check("midrst_out", out, 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    run("after_rst", fill_x(16'h0100), fill_w(16'h0080), '0, 16'h0480, 16'h0480);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias();
    test_sign_floor();
    test_wrap();
    test_backpressure();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
